// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one bus transaction per MEM instruction,
// holding the pipeline while the word-addressed bus access is outstanding.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic          r_timed_out;
  logic          r_is_load;
  logic [2:0]    r_funct3;
  logic [1:0]    r_lane;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wstrb;
  logic [31:0]   r_load_data;

  logic          w_rw_req;
  logic          w_f3_ok;
  logic          w_aligned;
  logic          w_access;
  logic          w_bad;
  logic          w_timeout;
  logic [3:0]    w_wstrb;
  logic [31:0]   w_wdata;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load_ext;

  // Request decode: unsigned sizes exist only for loads.
  always_comb begin
    w_rw_req = valid & (mem_read | mem_write);
    case (funct3)
      3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
      3'b100, 3'b101:         w_f3_ok = mem_read;
      default:                w_f3_ok = 1'b0;
    endcase
    case (funct3[1:0])
      2'b00:   w_aligned = 1'b1;
      2'b01:   w_aligned = ~addr[0];
      2'b10:   w_aligned = (addr[1:0] == 2'b00);
      default: w_aligned = 1'b0;
    endcase
    w_access = valid & (mem_read ^ mem_write) & w_f3_ok & w_aligned;
    w_bad    = w_rw_req & ~w_access;
  end

  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = 32'h0;
    if (mem_write) begin
      case (funct3[1:0])
        2'b00: begin
          w_wstrb = 4'b0001 << addr[1:0];
          w_wdata = {4{store_data[7:0]}};
        end
        2'b01: begin
          w_wstrb = 4'b0011 << addr[1:0];
          w_wdata = {2{store_data[15:0]}};
        end
        default: begin
          w_wstrb = 4'b1111;
          w_wdata = store_data;
        end
      endcase
    end
  end

  // Lane selection uses the latched address because addr may move during BUSY.
  always_comb begin
    w_byte = mem_rdata[8*r_lane +: 8];
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_ext = {24'h0, w_byte};
      3'b101:  w_load_ext = {16'h0, w_half};
      default: w_load_ext = mem_rdata;
    endcase
  end

  assign w_timeout = (r_state == S_BUSY) & ~mem_ack & (r_cnt == CNT_LAST);

  always_comb begin
    w_state_next = r_state;
    stall        = 1'b0;
    fault        = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall = w_access;
        fault = w_bad;
        if (w_access) w_state_next = S_BUSY;
      end
      S_BUSY: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        mem_we  = ~r_is_load;
        if (mem_ack | w_timeout) w_state_next = S_DONE;
      end
      S_DONE: begin
        fault        = r_timed_out;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    // Reset releases the pipeline immediately, before the clearing edge.
    if (!rst_n) begin
      stall   = 1'b0;
      fault   = 1'b0;
      mem_req = 1'b0;
      mem_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_timed_out <= 1'b0;
      r_is_load   <= 1'b0;
      r_funct3    <= 3'b000;
      r_lane      <= 2'b00;
      r_mem_addr  <= 32'h0;
      r_wdata     <= 32'h0;
      r_wstrb     <= 4'b0000;
      r_load_data <= 32'h0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            r_mem_addr  <= {addr[31:2], 2'b00};
            r_wdata     <= w_wdata;
            r_wstrb     <= w_wstrb;
            r_is_load   <= mem_read;
            r_funct3    <= funct3;
            r_lane      <= addr[1:0];
            r_cnt       <= '0;
            r_timed_out <= 1'b0;
          end else if (w_bad) begin
            r_load_data <= 32'h0;
          end
        end
        S_BUSY: begin
          if (mem_ack) begin
            if (r_is_load) r_load_data <= w_load_ext;
          end else if (w_timeout) begin
            r_load_data <= 32'h0;
            r_timed_out <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE:  r_timed_out <= 1'b0;
        default: r_timed_out <= 1'b0;
      endcase
    end
  end

  assign load_data = r_load_data;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_wdata;
  assign mem_wstrb = r_wstrb;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed vector table, random transactions against
// an arithmetic reference model, and hand sequences for reset and timeout.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, mem_read, mem_write, mem_ack;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data, mem_rdata;

  logic        a_stall, a_fault, a_mem_req, a_mem_we;
  logic [31:0] a_load_data, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_wstrb;
  logic        b_stall, b_fault, b_mem_req, b_mem_we;
  logic [31:0] b_load_data, b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_wstrb;

  bit          use_t4;
  logic        x_stall, x_fault, x_mem_req, x_mem_we;
  logic [31:0] x_load_data, x_mem_addr, x_mem_wdata;
  logic [3:0]  x_mem_wstrb;

  int          n_tests;
  int          n_fail;
  bit [31:0]   m_ld;

  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .addr(addr), .store_data(store_data),
    .stall(a_stall), .load_data(a_load_data), .fault(a_fault),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_wstrb(a_mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  mem_stage_lsu #(.TIMEOUT(4)) u_dut_t4 (
    .clk(clk), .rst_n(rst_n), .valid(valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .addr(addr), .store_data(store_data),
    .stall(b_stall), .load_data(b_load_data), .fault(b_fault),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  assign x_stall     = use_t4 ? b_stall     : a_stall;
  assign x_fault     = use_t4 ? b_fault     : a_fault;
  assign x_mem_req   = use_t4 ? b_mem_req   : a_mem_req;
  assign x_mem_we    = use_t4 ? b_mem_we    : a_mem_we;
  assign x_load_data = use_t4 ? b_load_data : a_load_data;
  assign x_mem_addr  = use_t4 ? b_mem_addr  : a_mem_addr;
  assign x_mem_wdata = use_t4 ? b_mem_wdata : a_mem_wdata;
  assign x_mem_wstrb = use_t4 ? b_mem_wstrb : a_mem_wstrb;

  typedef struct {
    bit        v, rd, wr;
    bit [2:0]  f3;
    bit [31:0] a, sd, rdata;
    int        w;
    bit [31:0] e_ld;
    int        e_stall, e_fault, e_req;
    string     nm;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input bit v, rd, wr, input bit [2:0] f3,
                              input bit [31:0] a, sd, rdata, input int w,
                              input bit [31:0] e_ld, input int e_stall, e_fault, e_req,
                              input string nm);
    vec_t r;
    r.v = v; r.rd = rd; r.wr = wr; r.f3 = f3; r.a = a; r.sd = sd; r.rdata = rdata;
    r.w = w; r.e_ld = e_ld; r.e_stall = e_stall; r.e_fault = e_fault; r.e_req = e_req;
    r.nm = nm;
    return r;
  endfunction

  // Reference model: sizes in bytes, alignment by modulo, lanes by shifting.
  function automatic int m_size(input bit [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit m_legal(input bit v, rd, wr, input bit [2:0] f3, input bit [31:0] a);
    int sz = m_size(f3);
    int off = int'(a[1:0]);
    if (!v || rd == wr || sz == 0) return 1'b0;
    if (wr && f3[2]) return 1'b0;
    return (off % sz) == 0;
  endfunction

  function automatic bit [3:0] m_strb(input bit [2:0] f3, input bit [31:0] a);
    int sz = m_size(f3);
    int off = int'(a[1:0]);
    int s = ((1 << sz) - 1) << off;
    return 4'(s);
  endfunction

  function automatic bit [31:0] m_wdata(input bit [2:0] f3, input bit [31:0] sd);
    int sz = m_size(f3);
    longint unsigned mask = (64'd1 << (8 * sz)) - 64'd1;
    longint unsigned w = 64'd0;
    for (int i = 0; i < 4 / sz; i++) w = w | ((64'(sd) & mask) << (8 * sz * i));
    return 32'(w);
  endfunction

  function automatic bit [31:0] m_load(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] rdata);
    int sz = m_size(f3);
    int off = int'(a[1:0]);
    longint unsigned v;
    if (sz == 4) return rdata;
    v = (64'(rdata) >> (8 * off)) & ((64'd1 << (8 * sz)) - 64'd1);
    if (!f3[2] && v >= (64'd1 << (8 * sz - 1))) v = v + (64'd1 << 32) - (64'd1 << (8 * sz));
    return 32'(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, rd, wr, input bit [2:0] f3, input bit [31:0] a, sd);
    valid = v; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
  endtask

  // One MEM instruction from presentation to the first IDLE cycle afterwards.
  task automatic do_txn(input bit v, rd, wr, input bit [2:0] f3, input bit [31:0] a, sd, rdata,
                        input int wait_n, output int n_stall, output int n_fault,
                        output int n_req, output bit [31:0] ld_end);
    int  t_lim;
    bit  legal, bad, timed_out, done;
    int  k, e_stall;
    t_lim = use_t4 ? 4 : 8;
    legal = m_legal(v, rd, wr, f3, a);
    bad = v && (rd || wr) && !legal;
    timed_out = 1'b0;
    n_stall = 0; n_fault = 0; n_req = 0;
    drive(v, rd, wr, f3, a, sd);
    mem_ack = 1'b0; mem_rdata = $urandom;
    @(negedge clk);
    chk("c0_stall", x_stall, legal);
    chk("c0_fault", x_fault, bad);
    chk("c0_req", x_mem_req, 0);
    n_stall += int'(x_stall); n_fault += int'(x_fault); n_req += int'(x_mem_req);
    next_cycle();
    if (legal) begin
      k = 0; done = 1'b0;
      while (!done) begin
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              3'($urandom), $urandom, $urandom);
        mem_ack = (k == wait_n);
        mem_rdata = (k == wait_n) ? rdata : $urandom;
        @(negedge clk);
        chk("busy_req", x_mem_req, 1);
        chk("busy_stall", x_stall, 1);
        chk("busy_fault", x_fault, 0);
        chk("busy_we", x_mem_we, wr);
        chk("busy_addr", x_mem_addr, {a[31:2], 2'b00});
        chk("busy_wstrb", x_mem_wstrb, wr ? m_strb(f3, a) : 4'b0000);
        if (wr) chk("busy_wdata", x_mem_wdata, m_wdata(f3, sd));
        n_stall += int'(x_stall); n_fault += int'(x_fault); n_req += int'(x_mem_req);
        if (k == wait_n) done = 1'b1;
        else if (k == t_lim - 1) begin done = 1'b1; timed_out = 1'b1; end
        k++;
        next_cycle();
      end
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom), $urandom, $urandom);
      mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      if (timed_out) m_ld = 32'h0;
      else if (rd) m_ld = m_load(f3, a, rdata);
      @(negedge clk);
      chk("done_stall", x_stall, 0);
      chk("done_req", x_mem_req, 0);
      chk("done_fault", x_fault, timed_out);
      chk("done_ld", x_load_data, m_ld);
      n_stall += int'(x_stall); n_fault += int'(x_fault); n_req += int'(x_mem_req);
      next_cycle();
    end else if (bad) begin
      m_ld = 32'h0;
    end
    valid = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    chk("idle_ld", x_load_data, m_ld);
    chk("idle_stall", x_stall, 0);
    chk("idle_fault", x_fault, 0);
    chk("idle_req", x_mem_req, 0);
    ld_end = x_load_data;
    e_stall = !legal ? 0 : (wait_n < t_lim ? wait_n + 2 : t_lim + 1);
    chk("stall_cycles", n_stall, e_stall);
    next_cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    m_ld = 32'h0;
  endtask

  initial begin
    int        ns, nf, nr;
    bit [31:0] ld;
    n_tests = 0; n_fail = 0; use_t4 = 1'b0; m_ld = 32'h0;

    tbl[0]  = mk(1,1,0,3'd0,32'h103,32'h0,32'h80FF_0000,0,32'hFFFF_FF80,2,0,1,"lb_neg");
    tbl[1]  = mk(1,0,1,3'd1,32'h202,32'h0000_ABCD,32'h0,0,32'hFFFF_FF80,2,0,1,"sh_hi");
    tbl[2]  = mk(1,1,0,3'd2,32'h006,32'h0,32'h0,0,32'h0,0,1,0,"lw_misalign");
    tbl[3]  = mk(1,1,0,3'd5,32'h010,32'h0,32'h1234_F00D,5,32'h0000_F00D,7,0,6,"lhu_wait5");
    tbl[4]  = mk(1,1,0,3'd1,32'h012,32'h0,32'h8001_7FFF,1,32'hFFFF_8001,3,0,2,"lh_upper");
    tbl[5]  = mk(1,1,0,3'd4,32'h101,32'h0,32'h0000_9A00,0,32'h0000_009A,2,0,1,"lbu_lane1");
    tbl[6]  = mk(1,0,1,3'd0,32'h001,32'h1234_5678,32'h0,2,32'h0000_009A,4,0,3,"sb_lane1");
    tbl[7]  = mk(1,1,0,3'd2,32'h020,32'h0,32'hDEAD_BEEF,7,32'hDEAD_BEEF,9,0,8,"lw_last_ack");
    tbl[8]  = mk(0,1,0,3'd2,32'h024,32'h0,32'h0,0,32'hDEAD_BEEF,0,0,0,"not_valid");
    tbl[9]  = mk(1,1,1,3'd2,32'h028,32'h0,32'h0,0,32'h0,0,1,0,"rd_and_wr");
    tbl[10] = mk(1,1,0,3'd2,32'h02C,32'h0,32'h0BAD_CAFE,0,32'h0BAD_CAFE,2,0,1,"lw_plain");
    tbl[11] = mk(1,0,1,3'd4,32'h030,32'h0,32'h0,0,32'h0,0,1,0,"store_f3_100");
    tbl[12] = mk(1,1,0,3'd0,32'h033,32'h0,32'h7F00_0000,0,32'h0000_007F,2,0,1,"lb_pos");
    tbl[13] = mk(1,1,0,3'd3,32'h040,32'h0,32'h0,0,32'h0,0,1,0,"load_f3_011");
    tbl[14] = mk(1,1,0,3'd2,32'h048,32'h0,32'h1111_1111,1,32'h1111_1111,3,0,2,"lw_wait1");
    tbl[15] = mk(1,1,0,3'd2,32'h04C,32'h0,32'h2222_2222,8,32'h0,9,1,8,"lw_timeout");
    tbl[16] = mk(1,0,1,3'd2,32'h050,32'h89AB_CDEF,32'h0,0,32'h0,2,0,1,"sw_plain");
    tbl[17] = mk(1,1,0,3'd1,32'h053,32'h0,32'h0,0,32'h0,0,1,0,"lh_misalign");
    tbl[18] = mk(1,0,0,3'd2,32'h054,32'h0,32'h0,0,32'h0,0,0,0,"no_op");

    // Reset state, with a legal request presented while reset is held.
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 3'd2, 32'h100, 32'h0);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_stall", x_stall, 0);
    chk("rst_fault", x_fault, 0);
    chk("rst_req", x_mem_req, 0);
    chk("rst_we", x_mem_we, 0);
    chk("rst_ld", x_load_data, 0);
    chk("rst_addr", x_mem_addr, 0);
    chk("rst_wdata", x_mem_wdata, 0);
    chk("rst_wstrb", x_mem_wstrb, 0);
    next_cycle();
    rst_n = 1'b1; valid = 1'b0; m_ld = 32'h0;
    next_cycle();

    for (int i = 0; i < 19; i++) begin
      do_txn(tbl[i].v, tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].a, tbl[i].sd, tbl[i].rdata,
             tbl[i].w, ns, nf, nr, ld);
      chk($sformatf("%s_ld", tbl[i].nm), ld, tbl[i].e_ld);
      chk($sformatf("%s_stall", tbl[i].nm), ns, tbl[i].e_stall);
      chk($sformatf("%s_fault", tbl[i].nm), nf, tbl[i].e_fault);
      chk($sformatf("%s_req", tbl[i].nm), nr, tbl[i].e_req);
      $display("[TB] vec %0d %s addr=%h ld=%h stall=%0d", i, tbl[i].nm, tbl[i].a, ld, ns);
    end

    // A stray ack while idle must not disturb load_data.
    do_txn(1, 1, 0, 3'd2, 32'h30, 32'h0, 32'h55AA_55AA, 0, ns, nf, nr, ld);
    chk("pre_idle_ack_ld", ld, 32'h55AA_55AA);
    valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hA5A5_A5A5;
    @(negedge clk);
    chk("idle_ack_req", x_mem_req, 0);
    chk("idle_ack_stall", x_stall, 0);
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_ld", x_load_data, 32'h55AA_55AA);
    $display("[TB] seq idle_ack ld=%h", x_load_data);
    next_cycle();

    // Reset during BUSY, then a late ack right after release.
    drive(1'b1, 1'b1, 1'b0, 3'd2, 32'h44, 32'h0);
    @(negedge clk);
    chk("rb_stall_idle", x_stall, 1);
    next_cycle();
    valid = 1'b0;
    @(negedge clk);
    chk("rb_req_busy", x_mem_req, 1);
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rb_stall_in_rst", x_stall, 0);
    chk("rb_fault_in_rst", x_fault, 0);
    next_cycle();
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("rb_req_after", x_mem_req, 0);
    chk("rb_ld_after", x_load_data, 0);
    chk("rb_addr_after", x_mem_addr, 0);
    chk("rb_wstrb_after", x_mem_wstrb, 0);
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("rb_ld_late_ack", x_load_data, 0);
    chk("rb_req_late_ack", x_mem_req, 0);
    chk("rb_stall_late_ack", x_stall, 0);
    $display("[TB] seq reset_in_busy ld=%h req=%b", x_load_data, x_mem_req);
    m_ld = 32'h0;
    next_cycle();

    // Random transactions against the reference model.
    for (int i = 0; i < 150; i++) begin
      bit        rv, rrd, rwr;
      bit [2:0]  rf3;
      bit [31:0] ra;
      int        sel, rw;
      rv = ($urandom_range(0, 9) != 0);
      sel = int'($urandom_range(0, 7));
      rrd = (sel <= 3) || (sel == 6);
      rwr = (sel == 4) || (sel == 5) || (sel == 6);
      rf3 = 3'($urandom);
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
      rw = int'($urandom_range(0, 9));
      do_txn(rv, rrd, rwr, rf3, ra, $urandom, $urandom, rw, ns, nf, nr, ld);
      $display("[TB] rnd %0d v=%b r=%b w=%b f3=%0d addr=%h wait=%0d ld=%h stall=%0d",
               i, rv, rrd, rwr, rf3, ra, rw, ld, ns);
    end

    // Bus timeout on the TIMEOUT=4 instance.
    do_reset();
    use_t4 = 1'b1;
    next_cycle();
    do_txn(1, 1, 0, 3'd2, 32'h44, 32'h0, 32'hCAFE_F00D, 1, ns, nf, nr, ld);
    chk("t4_pre_ld", ld, 32'hCAFE_F00D);
    do_txn(1, 1, 0, 3'd2, 32'h40, 32'h0, 32'h0, 50, ns, nf, nr, ld);
    chk("t4_to_ld", ld, 32'h0);
    chk("t4_to_stall", ns, 5);
    chk("t4_to_fault", nf, 1);
    chk("t4_to_req", nr, 4);
    $display("[TB] seq timeout4 ld=%h stall=%0d fault=%0d req=%0d", ld, ns, nf, nr);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max cycles in BUSY waiting for mem_ack before a bus error.
REQ-002 SHALL have clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have valid  input  1  an instruction is present in MEM.
REQ-005 SHALL have mem_read, mem_write  input  1 each  load and store request from EX/MEM.
REQ-006 SHALL have funct3  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have addr, store_data  input  32 each  byte address and unshifted store value.
REQ-008 SHALL have stall  output  1  hold IF..MEM pipeline registers.
REQ-009 SHALL have load_data  output  32  aligned, extended load result; feeds MEM/WB mem_data_in.
REQ-010 SHALL have fault  output  1  one-cycle pulse: misaligned, illegal funct3, read+write, or bus timeout.
REQ-011 SHALL have mem_req, mem_we  output  1 each  bus request and write enable.
REQ-012 SHALL have mem_addr, mem_wdata  output  32 each  word address ({addr[31:2],2'b00}) and lane-replicated write data.
REQ-013 SHALL have mem_wstrb  output  4  byte enables, all 0 for reads.
REQ-014 SHALL have mem_ack  input  1  one-cycle completion pulse; mem_rdata  input  32  valid when mem_ack=1.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-016 Access = valid & (mem_read ^ mem_write) & legal funct3 & aligned; stores legal only for funct3 000/001/010.
REQ-017 Aligned: H/HU requires addr[0]=0; W requires addr[1:0]=00; B/BU always aligned.
REQ-018 IDLE with access: stall=1 combinationally; latch addr/funct3/type/data; next state BUSY.
REQ-019 IDLE with valid & (mem_read|mem_write) but not access: no request, fault=1 that cycle, stall=0, load_data <= 0, stay IDLE.
REQ-020 BUSY: mem_req=1, mem_addr/mem_we/mem_wdata/mem_wstrb stable from latched values; stall=1.
REQ-021 BUSY with mem_ack: load path captures rdata; next state DONE.
REQ-022 BUSY counter counts cycles without ack; when it reaches TIMEOUT: load_data <= 0, fault pulse in the DONE cycle, next state DONE.
REQ-023 DONE: stall=0, mem_req=0, load_data valid; unconditional return to IDLE (current MEM instruction is consumed and not re-issued).
REQ-024 Minimum latency: access seen cycle N, mem_req cycle N+1, ack N+1, DONE N+2; stall high for 2 cycles.
REQ-025 Store strobes: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111; wdata = byte replicated x4 (SB), half replicated x2 (SH), word (SW).
REQ-026 Load extract: byte = rdata lane addr[1:0], half = lane addr[1]; B/H sign-extend bit 7/15; BU/HU zero-extend; W unchanged.
REQ-027 load_data SHALL hold its value until the next completed load, fault, or reset; stores do not change it.
REQ-028 mem_ack outside BUSY SHALL be ignored.

Reset
REQ-029 rst_n=0 at any edge SHALL force: state IDLE, counter 0, load_data 0, mem_req/mem_we 0, mem_wstrb 0, mem_addr/mem_wdata 0, fault 0.
REQ-030 While rst_n=0, stall SHALL be 0; an outstanding bus access is abandoned and a late mem_ack is ignored.

Verification
REQ-031 LB addr 0x103, rdata 0x80FF_0000 ack next cycle -> mem_addr 0x100, wstrb 0000, load_data 0xFFFF_FF80, stall 2 cycles.
REQ-032 SH addr 0x202, store_data 0x0000_ABCD -> mem_we=1, wstrb 1100, wdata 0xABCD_ABCD; load_data unchanged.
REQ-033 LW addr 0x06 -> no mem_req, fault=1 one cycle, stall=0, load_data 0.
REQ-034 LHU addr 0x10, ack after 5 wait cycles, rdata 0x1234_F00D -> stall 7 cycles, load_data 0x0000_F00D.
REQ-035 TIMEOUT=4, no ack -> BUSY 4 cycles, then DONE with fault=1, load_data 0, mem_req drops.
REQ-036 rst_n low in BUSY, mem_ack pulse one cycle after release -> IDLE, mem_req 0, load_data 0, ack ignored.
